gpio_port: RTL and testbench
============================

Name: gpio_port

Overview:
- Memory-mapped GPIO responder on the core's data bus.
- It is the target of the core's store/load accesses to the GPIO window at 0x5000_0000. Firmware drives LEDs by writing 1/0 to offset 0x00.
- Provides:
  - a registered output latch with per-pin output enable;
  - synchronized input sampling with rising-edge capture;
  - a level interrupt to the core.
- Read data has one-cycle synchronous latency, the same as the instruction memory, so the core's load path treats both identically.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32).
- BASE_ADDR, 32'h5000_0000, window base; decode is addr[31:8] == BASE_ADDR[31:8].

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- addr  input  32  byte address from the core data port
- wr_en  input  4  byte write enables; 0000 = read/idle
- wr_data  input  32  store data
- rd_data  output  32  load data, registered
- gpio_in  input  WIDTH  asynchronous pad inputs
- gpio_out  output  WIDTH  output latch (OUT register)
- gpio_oe  output  WIDTH  output enable (DIR register, 1 = drive)
- irq  output  1  level interrupt, |(RISE & IRQ_EN)

Behaviour:
- Register map (word offsets, addr[7:2]). Bits above WIDTH read 0 and ignore writes.
  - 0x00 OUT, RW.
  - 0x04 IN, RO, synchronized pin value.
  - 0x08 DIR, RW.
  - 0x0C RISE, W1C, rising-edge capture.
  - 0x10 IRQ_EN, RW.
  - Other offsets read 0; writes are ignored.
- Hit rules:
  - Hit = window match. Accesses outside the window: no register change; rd_data is loaded with 0.
  - addr[1:0] is ignored; accesses are word-aligned.
- Writes: on a hit, each wr_en[i] set updates byte i of the target register at the clk edge.
- Reads:
  - rd_data is updated every cycle with the value of the register at addr, as sampled on that edge (post-write value not visible until the next cycle).
  - Latency is one cycle.
  - A read-after-write to the same register in consecutive cycles returns the new value.
- Input path:
  - 2-flop synchronizer, then prev flop. in_sync is visible in IN two edges after a pad change.
  - rise = in_sync & ~prev. RISE[i] is set on the edge following in_sync[i] rising, i.e. the 3rd clk edge after the pad change.
- Simultaneous events:
  - A W1C clear and a new rise on the same bit in the same cycle leave the bit set (set wins).
  - Bits not written with 1 are untouched.
- irq: combinational from RISE and IRQ_EN; changes in the cycle after the register update.
- Reset (async, any time, including mid-access): all of the following clear to 0 immediately:
  - OUT, DIR, RISE, IRQ_EN, synchronizer and prev flops;
  - rd_data.
  - Consequently gpio_out = 0, gpio_oe = 0, irq = 0.
  - After release, no spurious RISE: prev is 0 and sync is 0, so a pin held high produces exactly one RISE, three edges after reset release.
- No wait states; every access completes in one cycle.

Decomposition:
- Shared header define.vh: register offset constants and GPIO_BASE (32'h5000_0000), used by this block and the core's address decoder.
- One sub-module, gpio_sync:
  - WIDTH-wide 2-flop synchronizer plus prev register;
  - outputs in_sync and rise;
  - same clk/rst.
- Register file and bus logic stay in gpio_port.

Test Plan:
- Reset values: assert rst mid-sequence with OUT=0xFF -> gpio_out, gpio_oe, irq, rd_data all 0 immediately. Read of 0x5000_0000 after release returns 0.
- LED write: wr_en=1111, addr 0x5000_0000, data 1 -> gpio_out=0x01 next edge. Then data 0 -> 0x00. Then wr_en=0010, data 0x0000_AB00 with OUT=0x01 -> OUT unchanged (WIDTH=8 ignores byte 1).
- Read latency: write DIR=0x5A, then read 0x5000_0008 -> rd_data=0x0000_005A exactly one edge after the read address is presented. Read 0x5000_0014 -> 0. Read 0x6000_0000 -> 0, no side effects.
- Input sync/edge: gpio_in[3] 0->1 between edges -> IN reads 0x08 from edge 2; RISE=0x08 from edge 3; irq stays 0 with IRQ_EN=0.
- Interrupt/W1C: with RISE=0x08, write IRQ_EN=0x08 -> irq=1. Write RISE=0x08 -> irq=0, RISE=0.
- Set-wins: with RISE[3]=1, pulse gpio_in[3] so that rise occurs in the same cycle as a W1C of 0x08 -> RISE[3] remains 1 and irq remains 1.

Source files
------------

// File: rtl/gpio_port_pkg.sv
// Shared GPIO definitions: window base, register offsets and the offset decoder.
// The core's address decoder imports GPIO_BASE from here as well.
package gpio_port_pkg;

    localparam logic [31:0] GPIO_BASE  = 32'h5000_0000;

    localparam logic [7:0]  OFF_OUT    = 8'h00;
    localparam logic [7:0]  OFF_IN     = 8'h04;
    localparam logic [7:0]  OFF_DIR    = 8'h08;
    localparam logic [7:0]  OFF_RISE   = 8'h0C;
    localparam logic [7:0]  OFF_IRQ_EN = 8'h10;

    typedef enum logic [2:0] {
        REG_OUT,
        REG_IN,
        REG_DIR,
        REG_RISE,
        REG_IRQ_EN,
        REG_NONE
    } reg_sel_e;

    // Takes the word index addr[7:2]; the byte lane bits never take part in decode.
    function automatic reg_sel_e decode_word(input logic [5:0] word);
        reg_sel_e sel;
        case (word)
            OFF_OUT[7:2]:    sel = REG_OUT;
            OFF_IN[7:2]:     sel = REG_IN;
            OFF_DIR[7:2]:    sel = REG_DIR;
            OFF_RISE[7:2]:   sel = REG_RISE;
            OFF_IRQ_EN[7:2]: sel = REG_IRQ_EN;
            default:         sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_port_if.sv
// Core data-port bus as seen by a memory-mapped responder: address, byte
// write enables, store data and registered load data.
interface gpio_port_if;

    logic [31:0] addr;
    logic [3:0]  wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output addr,
        output wr_en,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  wr_data,
        output rd_data
    );

endinterface

// File: rtl/gpio_sync.sv
// Two-flop pad synchronizer followed by a history flop for rising-edge detection.
module gpio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = gpio_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Clearing prev together with the synchronizer means a pin held high
    // through reset yields exactly one edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign in_sync = sync_q;
    assign rise    = sync_q & ~prev_q;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO responder: output latch, direction, synchronized inputs,
// W1C rising-edge capture and a level interrupt. Loads return one cycle later.
module gpio_port
    import gpio_port_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR = GPIO_BASE
) (
    input  logic             clk,
    input  logic             rst,
    gpio_port_if.slave       bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] rise_evt;
    logic             hit;
    logic             wr_hit;
    reg_sel_e         sel;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c_mask;
    logic             unused_bus_bits;

    gpio_sync #(
        .WIDTH(WIDTH)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .gpio_in (gpio_in),
        .in_sync (in_sync),
        .rise    (rise_evt)
    );

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    always_comb begin
        hit    = (bus.addr[31:8] == BASE_ADDR[31:8]);
        sel    = decode_word(bus.addr[7:2]);
        wr_hit = hit && (bus.wr_en != 4'b0000);
        wdata  = bus.wr_data[WIDTH-1:0];
        wmask  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wmask[i] = bus.wr_en[i / 8];
        end
    end

    // Byte-lane merge into the addressed register; RISE turns the written
    // ones into a clear mask, but a same-cycle edge still sets the bit.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        irq_en_d = irq_en_q;
        w1c_mask = '0;
        if (wr_hit) begin
            case (sel)
                REG_OUT:    out_d    = (out_q    & ~wmask) | (wdata & wmask);
                REG_DIR:    dir_d    = (dir_q    & ~wmask) | (wdata & wmask);
                REG_IRQ_EN: irq_en_d = (irq_en_q & ~wmask) | (wdata & wmask);
                REG_RISE:   w1c_mask = wdata & wmask;
                default:    ;
            endcase
        end
        rise_d = (rise_q & ~w1c_mask) | rise_evt;
    end

    always_comb begin
        rd_data_d = '0;
        if (hit) begin
            case (sel)
                REG_OUT:    rd_data_d = zext(out_q);
                REG_IN:     rd_data_d = zext(in_sync);
                REG_DIR:    rd_data_d = zext(dir_q);
                REG_RISE:   rd_data_d = zext(rise_q);
                REG_IRQ_EN: rd_data_d = zext(irq_en_q);
                default:    rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_q    <= '0;
            irq_en_q  <= '0;
            rd_data_q <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_q    <= rise_d;
            irq_en_q  <= irq_en_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign gpio_out    = out_q;
    assign gpio_oe     = dir_q;
    assign irq         = |(rise_q & irq_en_q);

    // Byte lanes, store bits and enables beyond WIDTH carry no meaning here.
    assign unused_bus_bits = ^{bus.addr[1:0], bus.wr_data, bus.wr_en};

endmodule

// File: tb/tb_gpio_port.sv
// Directed plus randomized bench for gpio_port, checked against a pad-history
// reference model of the register map.
module tb_gpio_port;
    import gpio_port_pkg::*;

    localparam int          W     = 8;
    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam logic [31:0] WMASK = 32'h0000_00FF;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;
    logic [W-1:0] pad;

    gpio_port_if bus ();

    gpio_port #(
        .WIDTH     (W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]  m_out, m_dir, m_rise, m_irq_en, m_rd;
    logic [W-1:0] pad_hist[$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r & WMASK;
    endfunction

    function automatic void model_reset();
        m_out = '0; m_dir = '0; m_rise = '0; m_irq_en = '0; m_rd = '0;
        pad_hist.delete();
    endfunction

    // A pad value becomes IN two edges after it is sampled; an edge is
    // recorded when the IN value rises relative to one edge earlier.
    function automatic void model_edge(input logic [31:0] a, input logic [3:0] be,
                                       input logic [31:0] d, input logic [W-1:0] p);
        int          k;
        logic [31:0] in_now, in_before, cur, clr, new_rise;
        logic        in_window;
        k         = pad_hist.size();
        in_now    = (k >= 2) ? 32'(pad_hist[k-2]) : 32'h0;
        in_before = (k >= 3) ? 32'(pad_hist[k-3]) : 32'h0;
        in_window = (a[31:8] == BASE[31:8]);
        case (a[7:0] & 8'hFC)
            8'h00:   cur = m_out;
            8'h04:   cur = in_now;
            8'h08:   cur = m_dir;
            8'h0C:   cur = m_rise;
            8'h10:   cur = m_irq_en;
            default: cur = 32'h0;
        endcase
        m_rd     = in_window ? cur : 32'h0;
        new_rise = in_now & ~in_before;
        clr      = 32'h0;
        if (in_window && be != 4'b0000) begin
            case (a[7:0] & 8'hFC)
                8'h00:   m_out    = merge(m_out, d, be);
                8'h08:   m_dir    = merge(m_dir, d, be);
                8'h0C:   clr      = merge(32'h0, d, be);
                8'h10:   m_irq_en = merge(m_irq_en, d, be);
                default: ;
            endcase
        end
        m_rise = ((m_rise & ~clr) | new_rise) & WMASK;
        pad_hist.push_back(p);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        checkOutput({tag, "_out"}, 32'(gpio_out), m_out);
        checkOutput({tag, "_oe"},  32'(gpio_oe),  m_dir);
        checkOutput({tag, "_irq"}, 32'(irq),      32'(|(m_rise & m_irq_en)));
        checkOutput({tag, "_rd"},  bus.rd_data,   m_rd);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [3:0] be,
                                 input logic [31:0] d, input logic [W-1:0] p);
        bus.addr    = a;
        bus.wr_en   = be;
        bus.wr_data = d;
        gpio_in     = p;
        @(posedge clk);
        model_edge(a, be, d, p);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pad = '0;
        bus.addr = '0; bus.wr_en = '0; bus.wr_data = '0; gpio_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        applyStimulus(BASE, 4'h0, 32'h0, pad);
        check_all("reset_read");
        checkOutput("reset_rd_zero", bus.rd_data, 32'h0);

        applyStimulus(BASE, 4'hF, 32'h1, pad);
        check_all("led_on");
        checkOutput("led_on_const", 32'(gpio_out), 32'h01);
        applyStimulus(BASE, 4'hF, 32'h0, pad);
        check_all("led_off");
        applyStimulus(BASE, 4'hF, 32'h1, pad);
        applyStimulus(BASE, 4'b0010, 32'h0000_AB00, pad);
        check_all("byte1_ignored");
        checkOutput("byte1_const", 32'(gpio_out), 32'h01);

        applyStimulus(BASE + 32'h8, 4'hF, 32'h5A, pad);
        check_all("dir_write");
        applyStimulus(BASE + 32'h8, 4'h0, 32'h0, pad);
        check_all("dir_read");
        checkOutput("dir_read_const", bus.rd_data, 32'h0000_005A);
        applyStimulus(BASE + 32'h14, 4'h0, 32'h0, pad);
        check_all("hole_read");
        applyStimulus(32'h6000_0000, 4'hF, 32'hFF, pad);
        check_all("outside");
        checkOutput("outside_out", 32'(gpio_out), 32'h01);

        pad[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(BASE + ((i == 3) ? 32'hC : 32'h4), 4'h0, 32'h0, pad);
            check_all($sformatf("sync%0d", i));
        end
        checkOutput("rise_captured", bus.rd_data, 32'h08);
        checkOutput("irq_masked", 32'(irq), 32'h0);

        applyStimulus(BASE + 32'h10, 4'hF, 32'h08, pad);
        check_all("irq_en");
        checkOutput("irq_on", 32'(irq), 32'h1);
        applyStimulus(BASE + 32'hC, 4'hF, 32'h08, pad);
        check_all("w1c");
        checkOutput("irq_off", 32'(irq), 32'h0);

        pad[3] = 1'b0;
        repeat (3) begin applyStimulus(BASE, 4'h0, 32'h0, pad); check_all("low_a"); end
        pad[3] = 1'b1;
        repeat (3) begin applyStimulus(BASE, 4'h0, 32'h0, pad); check_all("rearm"); end
        pad[3] = 1'b0;
        repeat (3) begin applyStimulus(BASE, 4'h0, 32'h0, pad); check_all("low_b"); end
        pad[3] = 1'b1;
        applyStimulus(BASE, 4'h0, 32'h0, pad);
        applyStimulus(BASE, 4'h0, 32'h0, pad);
        applyStimulus(BASE + 32'hC, 4'hF, 32'h08, pad);
        check_all("set_wins");
        checkOutput("set_wins_irq", 32'(irq), 32'h1);
        applyStimulus(BASE + 32'hC, 4'h0, 32'h0, pad);
        checkOutput("set_wins_rise", bus.rd_data, 32'h08);

        applyStimulus(BASE, 4'hF, 32'hFF, pad);
        check_all("pre_reset");
        #3 rst = 1'b1;
        #1;
        checkOutput("async_out", 32'(gpio_out), 32'h0);
        checkOutput("async_oe",  32'(gpio_oe),  32'h0);
        checkOutput("async_irq", 32'(irq),      32'h0);
        checkOutput("async_rd",  bus.rd_data,   32'h0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(BASE + 32'hC, 4'h0, 32'h0, pad);
            check_all($sformatf("post_reset%0d", i));
        end
        checkOutput("one_rise", bus.rd_data, 32'h08);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [3:0]  be;
            a = {BASE[31:8], 8'($urandom_range(0, 7) * 4 + $urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) a = $urandom;
            be = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 2) == 0) pad = pad ^ 8'($urandom);
            applyStimulus(a, be, $urandom, pad);
            check_all($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
